// File: rtl/multisim_loopback_pkg.sv
// Shared definitions for the multisim loopback concentrator.
// Stats counters are built only when MULTISIM_LOOPBACK_STATS_EN is defined.
package multisim_loopback_pkg;

    localparam int STAT_W = 32;

    typedef logic [STAT_W-1:0] stat_cnt_t;

    // Channel index width; never zero so a single-channel build still has a tag bit.
    function automatic int ch_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/multisim_loopback_fifo.sv
// Per-channel FIFO with wrapping pointers and an occupancy counter.
// full/empty are decoded from registered occupancy only.
module multisim_loopback_fifo
    import multisim_loopback_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  full,
    output logic                  empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W:0]        count;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  do_push;
    logic                  do_pop;

    assign full      = (count == (PTR_W+1)'(DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push & ~full;
    assign do_pop    = pop & ~empty;
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/multisim_loopback_mux.sv
// N-channel loopback concentrator: per-channel FIFOs drained round-robin into one registered beat.
// Define MULTISIM_LOOPBACK_STATS_EN to add per-channel accepted-beat counters on stat_cnt.
module multisim_loopback_mux
    import multisim_loopback_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4,
    localparam int CH_W      = ch_w(NUM_CH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CH-1:0]            in_vld,
    input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
    output logic [NUM_CH-1:0]            in_rdy,
    output logic                         out_vld,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [CH_W-1:0]              out_ch,
    input  logic                         out_rdy
`ifdef MULTISIM_LOOPBACK_STATS_EN
    ,
    output logic [NUM_CH*STAT_W-1:0]     stat_cnt
`endif
);

    // Handshake: a beat moves on any edge where valid & ready are both high; a
    // valid beat holds data stable until taken, and ready never depends on valid.

    logic [NUM_CH-1:0]     push;
    logic [NUM_CH-1:0]     pop;
    logic [NUM_CH-1:0]     full;
    logic [NUM_CH-1:0]     empty;
    logic [DATA_WIDTH-1:0] head [NUM_CH];
    logic [CH_W-1:0]       rr;
    logic                  load;
    logic                  grant_vld;
    logic [CH_W-1:0]       grant_ch;

    assign in_rdy = ~full;
    assign push   = in_vld & ~full;
    assign load   = ~out_vld | out_rdy;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign pop[i] = load & grant_vld & (grant_ch == CH_W'(i));

        multisim_loopback_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (push[i]),
            .push_data (in_data[i*DATA_WIDTH +: DATA_WIDTH]),
            .pop       (pop[i]),
            .head_data (head[i]),
            .full      (full[i]),
            .empty     (empty[i])
        );
    end

    // First non-empty channel at or above rr, wrapping modulo NUM_CH.
    always_comb begin
        grant_vld = 1'b0;
        grant_ch  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            int idx;
            idx = int'(rr) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!grant_vld && !empty[idx]) begin
                grant_vld = 1'b1;
                grant_ch  = CH_W'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld  <= 1'b0;
            out_data <= '0;
            out_ch   <= '0;
            rr       <= '0;
        end else if (load) begin
            out_vld <= grant_vld;
            if (grant_vld) begin
                out_data <= head[grant_ch];
                out_ch   <= grant_ch;
                rr       <= (grant_ch == CH_W'(NUM_CH-1)) ? '0 : grant_ch + 1'b1;
            end
        end
    end

`ifdef MULTISIM_LOOPBACK_STATS_EN
    for (genvar i = 0; i < NUM_CH; i++) begin : g_stat
        stat_cnt_t cnt_q;

        // Saturate rather than wrap so a long run never reports a small count.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
            end else if (push[i] && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end

        assign stat_cnt[i*STAT_W +: STAT_W] = cnt_q;
    end
`endif

endmodule
